// File: rtl/gray_seq_gen.sv
// -----------------------------------------------------------------------------
// gray_seq_gen
//
// Gray-code stimulus source for the downstream Gray-to-binary decoder. Keeps a
// binary count that steps up or down once every DIV clocks while running, and
// presents each count as its Gray code through a valid/ready handshake. A step
// that is due while the previous word is still unaccepted parks the generator
// in STALL until the word drains. wrap pulses with any word whose step crossed
// the all-ones / all-zeros boundary.
//
// State table:
//   state    | meaning
//   ---------+----------------------------------------------------------------
//   ST_IDLE  | count frozen; accepts load and start; pending word may drain
//   ST_RUN   | prescaler running, a step is taken every DIV cycles
//   ST_STALL | step due but the output word is still held; waits for ready
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   begin emitting (IDLE only, level sampled, not remembered)
//   stop      in   stop stepping and return to IDLE
//   up_dn     in   step direction: 1 = increment, 0 = decrement
//   load      in   preset the count from load_val (IDLE only)
//   load_val  in   binary preset value
//   gray_out  out  registered Gray code of the emitted count
//   valid     out  gray_out holds a word not yet accepted
//   ready     in   downstream accepts the word when valid && ready
//   wrap      out  one-cycle pulse with a word produced by a wrapping step
//   busy      out  high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module gray_seq_gen #(
    parameter int WIDTH = 4,
    parameter int DIV   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic             valid,
    input  logic             ready,
    output logic             wrap,
    output logic             busy
);

    // DIV = 1 still needs a one-bit prescaler; it simply never leaves 0.
    localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_gray;
    logic             r_valid;
    logic             r_wrap;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [PW-1:0]    w_presc_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_valid_nxt;
    logic             w_wrap_nxt;
    logic             w_do_step;
    logic             w_word_held;
    logic [WIDTH-1:0] w_step_cnt;
    logic             w_step_wrap;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // A word is "held" when it is presented and not taken this cycle; that is
    // what blocks both a due step and a start from IDLE.
    assign w_word_held = r_valid & ~ready;

    assign w_step_cnt  = up_dn ? (r_count + 1'b1) : (r_count - 1'b1);
    assign w_step_wrap = up_dn ? (r_count == CNT_MAX) : (r_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_gray  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_gray  <= w_gray_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_gray_nxt  = r_gray;
        // An accepted word drops valid unless a new word replaces it below.
        w_valid_nxt = w_word_held;
        w_wrap_nxt  = 1'b0;
        w_do_step   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (load) begin
                    w_count_nxt = load_val;
                end else if (start && !w_word_held) begin
                    // First word is the current count, emitted unstepped.
                    w_gray_nxt  = to_gray(r_count);
                    w_valid_nxt = 1'b1;
                    w_presc_nxt = '0;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_presc_nxt = '0;
                end else if (r_presc == PRESC_LAST) begin
                    if (!w_word_held) begin
                        w_do_step = 1'b1;
                    end else begin
                        // Prescaler stays at its last value while stalled.
                        w_state_nxt = ST_STALL;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end

            ST_STALL: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_presc_nxt = '0;
                end else if (ready) begin
                    w_do_step   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_presc_nxt = '0;
            end
        endcase

        if (w_do_step) begin
            w_count_nxt = w_step_cnt;
            w_gray_nxt  = to_gray(w_step_cnt);
            w_valid_nxt = 1'b1;
            w_wrap_nxt  = w_step_wrap;
            w_presc_nxt = '0;
        end
    end

    assign gray_out = r_gray;
    assign valid    = r_valid;
    assign wrap     = r_wrap;
    assign busy     = r_busy;

endmodule

// File: tb/tb_gray_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_gray_seq_gen
//
// Two instances (DIV = 1 and DIV = 3) share one stimulus stream. A behavioural
// model tracks each instance's count, step timer and pending word with plain
// integer arithmetic; outputs are compared one time unit after each rising
// edge. Directed sequences cover the listed scenarios, then random traffic
// with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_gray_seq_gen;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst, start, stop, up_dn, load, ready;
    logic [W-1:0] load_val;
    logic [W-1:0] g1, g3;
    logic         v1, v3, w1, w3, b1, b3;

    always #5 clk = ~clk;

    gray_seq_gen #(.WIDTH(W), .DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .gray_out(g1), .valid(v1),
        .ready(ready), .wrap(w1), .busy(b1)
    );

    gray_seq_gen #(.WIDTH(W), .DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .gray_out(g3), .valid(v3),
        .ready(ready), .wrap(w3), .busy(b3)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model: mode 0 = idle, 1 = running, 2 = waiting on ready
    int m_div[2] = '{1, 3};
    int m_mode[2], m_cnt[2], m_pre[2], m_gray[2], m_valid[2], m_wrap[2];

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d required %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_pre[k] = 0;
            m_gray[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs as they stand now.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int  mode, cnt, pre, gry, vld, wrp, nxt;
            bit  held, take_step;
            mode = m_mode[k]; cnt = m_cnt[k]; pre = m_pre[k]; gry = m_gray[k];
            held = (m_valid[k] != 0) && !ready;
            vld  = held ? 1 : 0;
            wrp  = 0;
            take_step = 0;
            if (mode == 0) begin
                if (stop) begin
                end else if (load) begin
                    cnt = int'(load_val);
                end else if (start && !held) begin
                    gry = gray_of(cnt); vld = 1; pre = 0; mode = 1;
                end
            end else if (mode == 1) begin
                if (stop) begin
                    mode = 0; pre = 0;
                end else if (pre == m_div[k] - 1) begin
                    if (held) mode = 2;
                    else take_step = 1;
                end else begin
                    pre = pre + 1;
                end
            end else begin
                if (stop) begin
                    mode = 0; pre = 0;
                end else if (ready) begin
                    take_step = 1; mode = 1;
                end
            end
            if (take_step) begin
                nxt = up_dn ? (cnt + 1) % M : (cnt + M - 1) % M;
                wrp = up_dn ? (cnt == M - 1) : (cnt == 0);
                cnt = nxt; gry = gray_of(nxt); vld = 1; pre = 0;
            end
            m_mode[k] = mode; m_cnt[k] = cnt; m_pre[k] = pre;
            m_gray[k] = gry; m_valid[k] = vld; m_wrap[k] = wrp;
        end
    endtask

    task automatic check_outputs();
        check_val("d1_gray",  32'(g1), 32'(m_gray[0]));
        check_val("d1_valid", 32'(v1), 32'(m_valid[0]));
        check_val("d1_wrap",  32'(w1), 32'(m_wrap[0]));
        check_val("d1_busy",  32'(b1), 32'(m_mode[0] != 0));
        check_val("d3_gray",  32'(g3), 32'(m_gray[1]));
        check_val("d3_valid", 32'(v3), 32'(m_valid[1]));
        check_val("d3_wrap",  32'(w3), 32'(m_wrap[1]));
        check_val("d3_busy",  32'(b3), 32'(m_mode[1] != 0));
    endtask

    // Called with clk low; returns at the next falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse entirely inside the low clock phase.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; up_dn = 1'b1;
        load = 1'b0; load_val = '0; ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // DIV=1 up count from 0 with ready held: full cycle including wrap.
        start = 1'b1; up_dn = 1'b1; ready = 1'b1;
        tick();
        check_val("seq_first", 32'(g1), 32'd0);
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_val("seq_gray", 32'(g1), 32'(gray_of(i % 16)));
            check_val("seq_wrap", 32'(w1), 32'(i == 16));
        end

        // Reset while valid is high takes effect without a clock edge.
        do_reset();
        check_val("rst_valid", 32'(v1), 32'd0);
        check_val("rst_busy",  32'(b1), 32'd0);

        // DIV=3: load 5, count down, ready held.
        load = 1'b1; load_val = 4'd5;
        tick();
        load = 1'b0; start = 1'b1; up_dn = 1'b0;
        tick();
        check_val("div3_w0", 32'(g3), 32'h7);
        start = 1'b0;
        tick();
        check_val("div3_gap1", 32'(v3), 32'd0);
        tick();
        check_val("div3_gap2", 32'(v3), 32'd0);
        tick();
        check_val("div3_w1", 32'(g3), 32'h6);
        check_val("div3_v1", 32'(v3), 32'd1);
        repeat (3) tick();
        check_val("div3_w2", 32'(g3), 32'h2);

        // Stall: ready low for 4 cycles after the first word.
        do_reset();
        up_dn = 1'b1; ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("stall_gray",  32'(g1), 32'd0);
            check_val("stall_valid", 32'(v1), 32'd1);
            check_val("stall_busy",  32'(b1), 32'd1);
        end
        ready = 1'b1;
        tick();
        check_val("unstall_gray",  32'(g1), 32'd1);
        check_val("unstall_valid", 32'(v1), 32'd1);

        // stop while stalled: back to IDLE, word kept until accepted.
        ready = 1'b0;
        repeat (2) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("stop_busy",  32'(b1), 32'd0);
        check_val("stop_valid", 32'(v1), 32'd1);
        check_val("stop_gray",  32'(g1), 32'd1);
        tick();
        ready = 1'b1;
        tick();
        check_val("drain_valid", 32'(v1), 32'd0);
        check_val("drain_gray",  32'(g1), 32'd1);

        // Same-cycle IDLE events, then a down step wrapping from 0.
        do_reset();
        start = 1'b1; stop = 1'b1;
        tick();
        check_val("startstop_busy", 32'(b1), 32'd0);
        stop = 1'b0; load = 1'b1; load_val = 4'd9;
        tick();
        check_val("loadstart_busy", 32'(b1), 32'd0);
        check_val("loadstart_vld",  32'(v1), 32'd0);
        start = 1'b0; load_val = 4'd0;
        tick();
        load = 1'b0; start = 1'b1; up_dn = 1'b0;
        tick();
        check_val("dn_first", 32'(g1), 32'd0);
        check_val("dn_first_wrap", 32'(w1), 32'd0);
        start = 1'b0;
        tick();
        check_val("dn_wrap_gray", 32'(g1), 32'h8);
        check_val("dn_wrap",      32'(w1), 32'd1);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom);
            ready    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gray_seq_gen.md
Name: gray_seq_gen

Overview:
Gray-code sequence source placed directly upstream of the Gray-to-binary decoder stage. It keeps an internal binary count and steps it up or down at a programmable rate. Each count is presented on gray_out as its Gray-code equivalent through a valid/ready handshake. It gives the decoder a controllable, stallable stimulus stream and flags counter wrap-around.

Parameters:
WIDTH, 4, bit width of the count and of gray_out
DIV, 3, clock cycles per step in RUN; legal values are 1 or more, and 1 means one step per cycle

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  level-sampled request to begin emitting; honoured only in IDLE
stop  in  1  request to stop stepping and return to IDLE
up_dn  in  1  step direction: 1 = increment, 0 = decrement; sampled at each step
load  in  1  writes load_val into the count; honoured only in IDLE
load_val  in  WIDTH  binary preset value
gray_out  out  WIDTH  registered Gray code of the emitted count, computed as bin ^ (bin >> 1)
valid  out  1  gray_out holds a word not yet accepted
ready  in  1  downstream accepts a word when valid && ready
wrap  out  1  one-cycle pulse, coincident with the word produced by a wrapping step
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst = 0, asynchronous, at any time including mid-transfer):
  - state = IDLE, count = 0, prescaler = 0
  - gray_out = 0, valid = 0, wrap = 0, busy = 0
  - Operation resumes on the first rising clk edge after rst returns to 1.
- States:
  - IDLE: count frozen.
    - load = 1 sets count <= load_val.
    - start = 1 with load = 0 and stop = 0 gives: gray_out <= gray(count), valid <= 1, prescaler <= 0, state -> RUN. The current count is emitted unstepped.
    - Priority in IDLE is stop > load > start. An ignored start is not remembered.
  - RUN: the prescaler counts 0..DIV-1. At prescaler == DIV-1 a step is due.
    - If valid == 0 or ready == 1 in that cycle: count <= count ± 1 (mod 2^WIDTH), gray_out <= gray(new count), valid <= 1, prescaler <= 0.
    - Otherwise: prescaler holds at DIV-1 and state -> STALL.
  - STALL: waits for ready.
    - In a cycle with ready == 1 the held word transfers. In that same edge: step, present the new word (valid stays 1), prescaler <= 0, state -> RUN.
- Handshake:
  - gray_out and valid hold stable while valid && !ready.
  - valid && ready with no step in the same cycle gives valid <= 0 next cycle.
  - valid && ready with a step in the same cycle gives a back-to-back word, and valid remains 1.
- stop in RUN or STALL:
  - State -> IDLE next cycle. No step occurs in that cycle, even if one is due. Prescaler <= 0.
  - A pending word keeps valid = 1 until accepted, even in IDLE.
  - start in IDLE while valid == 1 && ready == 0 is ignored.
- wrap:
  - Asserted for exactly one cycle with the new word when an up step goes from 2^WIDTH-1 to 0, or a down step goes from 0 to 2^WIDTH-1.
  - Never asserted on start or load.
- load and up_dn changes outside their sampling points have no effect.
- All outputs are registered; gray_out appears one cycle after the deciding edge.

Test Plan:
- Reset with DIV=1, rst=0 mid-run while valid=1 -> gray_out, valid, wrap and busy go to 0 immediately, without waiting for a clk edge; state returns to IDLE.
- DIV=1, count=0, start, up_dn=1, ready=1 held -> gray_out sequence 0000,0001,0011,0010,0110,... on consecutive cycles. At the 1111 -> 0000 step, gray_out=0000 with wrap=1 for one cycle.
- DIV=3, load load_val=5, start, up_dn=0, ready=1 -> first word 0111 (gray 5), then 0110 (gray 4) three cycles later, then 0010 (gray 3). valid deasserts between words.
- DIV=1, ready held 0 for 4 cycles after the first word -> gray_out and valid stable, busy=1. On the ready=1 cycle the next word appears on the following edge with valid continuously 1.
- Count=0, up_dn=0, DIV=1, ready=1 -> second word 1000 (gray 15) with wrap=1.
- Same-cycle events: start+stop in IDLE -> stays IDLE. load+start in IDLE -> count loaded, stays IDLE. stop in STALL -> IDLE, old word kept valid until ready, no further step.
